// File: rtl/cavlc_pkg.sv
// Shared CAVLC parse definitions: coeff_token length bounds, decoded token layout, nC table class.
package cavlc_pkg;

  localparam int MAX_CT_LEN = 10;
  localparam int MIN_CT_LEN = 4;

  typedef enum logic [1:0] {
    NC_0TO2 = 2'd0,
    NC_2TO4 = 2'd1,
    NC_4TO8 = 2'd2,
    NC_8UP  = 2'd3
  } nc_class_t;

  typedef struct packed {
    logic [1:0] t1s;
    logic [4:0] tc;
    logic [3:0] len;
  } ct_tok_t;

endpackage

// File: rtl/coeff_token_nc4to8_match.sv
// Combinational coeff_token lookup for the 4 <= nC < 8 table; zero latency, no flow control.
module coeff_token_nc4to8_match
  import cavlc_pkg::*;
(
  input  logic [3:0]            len,
  input  logic [MAX_CT_LEN-1:0] bits,
  output logic                  hit,
  output logic [1:0]            t1s,
  output logic [4:0]            tc
);

  logic [MAX_CT_LEN-1:0] w_bits;
  logic [6:0]            w_res;
  logic                  w_hit;

  // Only the low len bits carry codeword content.
  assign w_bits = bits & ((10'd1 << len) - 10'd1);

  always_comb begin
    w_hit = 1'b1;
    w_res = 7'd0;
    case ({len, w_bits})
      {4'd4,  10'b1111}:       w_res = {2'd0, 5'd0};
      {4'd6,  10'b001111}:     w_res = {2'd0, 5'd1};
      {4'd4,  10'b1110}:       w_res = {2'd1, 5'd1};
      {4'd6,  10'b001011}:     w_res = {2'd0, 5'd2};
      {4'd5,  10'b01111}:      w_res = {2'd1, 5'd2};
      {4'd4,  10'b1101}:       w_res = {2'd2, 5'd2};
      {4'd6,  10'b001000}:     w_res = {2'd0, 5'd3};
      {4'd5,  10'b01100}:      w_res = {2'd1, 5'd3};
      {4'd5,  10'b01110}:      w_res = {2'd2, 5'd3};
      {4'd4,  10'b1100}:       w_res = {2'd3, 5'd3};
      {4'd7,  10'b0001111}:    w_res = {2'd0, 5'd4};
      {4'd5,  10'b01010}:      w_res = {2'd1, 5'd4};
      {4'd5,  10'b01011}:      w_res = {2'd2, 5'd4};
      {4'd4,  10'b1011}:       w_res = {2'd3, 5'd4};
      {4'd7,  10'b0001011}:    w_res = {2'd0, 5'd5};
      {4'd5,  10'b01000}:      w_res = {2'd1, 5'd5};
      {4'd5,  10'b01001}:      w_res = {2'd2, 5'd5};
      {4'd4,  10'b1010}:       w_res = {2'd3, 5'd5};
      {4'd7,  10'b0001001}:    w_res = {2'd0, 5'd6};
      {4'd6,  10'b001110}:     w_res = {2'd1, 5'd6};
      {4'd6,  10'b001101}:     w_res = {2'd2, 5'd6};
      {4'd4,  10'b1001}:       w_res = {2'd3, 5'd6};
      {4'd7,  10'b0001000}:    w_res = {2'd0, 5'd7};
      {4'd6,  10'b001010}:     w_res = {2'd1, 5'd7};
      {4'd6,  10'b001001}:     w_res = {2'd2, 5'd7};
      {4'd4,  10'b1000}:       w_res = {2'd3, 5'd7};
      {4'd8,  10'b00001111}:   w_res = {2'd0, 5'd8};
      {4'd7,  10'b0001110}:    w_res = {2'd1, 5'd8};
      {4'd7,  10'b0001101}:    w_res = {2'd2, 5'd8};
      {4'd5,  10'b01101}:      w_res = {2'd3, 5'd8};
      {4'd8,  10'b00001011}:   w_res = {2'd0, 5'd9};
      {4'd8,  10'b00001110}:   w_res = {2'd1, 5'd9};
      {4'd7,  10'b0001010}:    w_res = {2'd2, 5'd9};
      {4'd6,  10'b001100}:     w_res = {2'd3, 5'd9};
      {4'd9,  10'b000001111}:  w_res = {2'd0, 5'd10};
      {4'd8,  10'b00001010}:   w_res = {2'd1, 5'd10};
      {4'd8,  10'b00001101}:   w_res = {2'd2, 5'd10};
      {4'd7,  10'b0001100}:    w_res = {2'd3, 5'd10};
      {4'd9,  10'b000001011}:  w_res = {2'd0, 5'd11};
      {4'd9,  10'b000001110}:  w_res = {2'd1, 5'd11};
      {4'd8,  10'b00001001}:   w_res = {2'd2, 5'd11};
      {4'd8,  10'b00001100}:   w_res = {2'd3, 5'd11};
      {4'd9,  10'b000001000}:  w_res = {2'd0, 5'd12};
      {4'd9,  10'b000001010}:  w_res = {2'd1, 5'd12};
      {4'd9,  10'b000001101}:  w_res = {2'd2, 5'd12};
      {4'd8,  10'b00001000}:   w_res = {2'd3, 5'd12};
      {4'd10, 10'b0000001101}: w_res = {2'd0, 5'd13};
      {4'd9,  10'b000000111}:  w_res = {2'd1, 5'd13};
      {4'd9,  10'b000001001}:  w_res = {2'd2, 5'd13};
      {4'd9,  10'b000001100}:  w_res = {2'd3, 5'd13};
      {4'd10, 10'b0000001001}: w_res = {2'd0, 5'd14};
      {4'd10, 10'b0000001100}: w_res = {2'd1, 5'd14};
      {4'd10, 10'b0000001011}: w_res = {2'd2, 5'd14};
      {4'd10, 10'b0000001010}: w_res = {2'd3, 5'd14};
      {4'd10, 10'b0000000101}: w_res = {2'd0, 5'd15};
      {4'd10, 10'b0000001000}: w_res = {2'd1, 5'd15};
      {4'd10, 10'b0000000111}: w_res = {2'd2, 5'd15};
      {4'd10, 10'b0000000110}: w_res = {2'd3, 5'd15};
      {4'd10, 10'b0000000001}: w_res = {2'd0, 5'd16};
      {4'd10, 10'b0000000100}: w_res = {2'd1, 5'd16};
      {4'd10, 10'b0000000011}: w_res = {2'd2, 5'd16};
      {4'd10, 10'b0000000010}: w_res = {2'd3, 5'd16};
      default:                 w_hit = 1'b0;
    endcase
  end

  assign hit = w_hit;
  assign t1s = w_res[6:5];
  assign tc  = w_res[4:0];

endmodule

// File: rtl/coeff_token_nc4to8_decoder.sv
// Bit-serial coeff_token decoder (4 <= nC < 8): token valid the cycle after the last bit;
// while a token waits on tok_ready, or after an unmatched 10-bit string, no bits are accepted.
module coeff_token_nc4to8_decoder
  import cavlc_pkg::*;
#(
  parameter int MAXLEN = 10,
  parameter int LWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [1:0]        trailing_ones,
  output logic [4:0]        total_coeff,
  output logic [LWIDTH-1:0] code_len,
  output logic              err
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_ERROR   = 2'd2;

  logic [1:0]        r_state;
  logic [MAXLEN-1:0] r_shreg;
  logic [3:0]        r_cnt;
  ct_tok_t           r_tok;
  logic              r_err;

  logic              w_take;
  logic [MAXLEN-1:0] w_next;
  logic [3:0]        w_len;
  logic              w_hit;
  logic [1:0]        w_t1s;
  logic [4:0]        w_tc;

  assign w_take = bit_valid & bit_ready;
  assign w_next = {r_shreg[MAXLEN-2:0], bit_in};
  assign w_len  = (r_cnt >= 4'(MAXLEN)) ? 4'(MAXLEN) : r_cnt + 4'd1;

  coeff_token_nc4to8_match u_match (
    .len  (w_len),
    .bits (w_next),
    .hit  (w_hit),
    .t1s  (w_t1s),
    .tc   (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COLLECT;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_tok   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= ST_COLLECT;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_tok   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_take) begin
            if (w_hit) begin
              r_tok   <= '{t1s: w_t1s, tc: w_tc, len: w_len};
              r_shreg <= '0;
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else if (w_len == 4'(MAXLEN)) begin
              // Only the all-zero string reaches full length unmatched.
              r_err   <= 1'b1;
              r_shreg <= '0;
              r_cnt   <= '0;
              r_state <= ST_ERROR;
            end else begin
              r_shreg <= w_next;
              r_cnt   <= w_len;
            end
          end
        end
        ST_HOLD: begin
          if (tok_ready) begin
            r_tok   <= '0;
            r_state <= ST_COLLECT;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  assign bit_ready     = (r_state == ST_COLLECT) & ~rst;
  assign tok_valid     = (r_state == ST_HOLD);
  assign trailing_ones = r_tok.t1s;
  assign total_coeff   = r_tok.tc;
  assign code_len      = LWIDTH'(r_tok.len);
  assign err           = r_err;

endmodule

// File: doc/coeff_token_nc4to8_decoder.md
# coeff_token_nc4to8_decoder

Serial-bitstream decoder for the CAVLC coeff_token syntax element, for the 4 <= nC < 8 table (H.264 Table 9-5, fourth column). It is the receive-side counterpart of the nC 4..7 coeff_token encoder table. The block accepts one bit per cycle over a valid/ready handshake and recognises a complete codeword of 4 to 10 bits. It then emits {TrailingOnes, TotalCoeff, code length} on an output handshake. It sits at the front of the CAVLC parse path, ahead of the level and run decoders.

## Interface
Parameters:
- MAXLEN, 10: longest codeword in bits; also the shift-register depth.
- LWIDTH, 4: width of the code_len output.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear: discards partial codeword, held token and error.
- bit_valid  in  1  bit_in is valid.
- bit_in  in  1  next bitstream bit, MSB-first within each codeword.
- bit_ready  out  1  block accepts a bit this cycle.
- tok_valid  out  1  decoded token present.
- tok_ready  in  1  downstream accepts the token.
- trailing_ones  out  2  T1s, 0..3.
- total_coeff  out  5  TotalCoeff, 0..16.
- code_len  out  LWIDTH  consumed codeword length, 4..10.
- err  out  1  sticky: 10 bits received without a match.

## Operation
- Three states: COLLECT, HOLD, ERROR. Reset state is COLLECT, with shreg = 0 and cnt = 0.
- All outputs reset to 0.
- bit_ready = (state == COLLECT).
- Bit accepted on bit_valid & bit_ready. For an accepted bit, next = {shreg, bit_in} and len = cnt + 1.
- Matching is done on (len, next) against the 62 legal codewords. Only the low len bits of next are significant.
- Match found:
  - register trailing_ones, total_coeff and code_len = len;
  - clear shreg and cnt;
  - go to HOLD.
- No match and len < 10: shreg <= next, cnt <= len, remain in COLLECT.
- No match and len == 10: this is only possible for "0000000000". Set err, go to ERROR.
- HOLD: tok_valid = 1 and outputs stay stable. On tok_ready go to COLLECT, drop tok_valid and zero the token outputs.
- ERROR: err = 1, bit_ready = 0, tok_valid = 0. Left only by flush or rst.
- flush has priority over every other event in the same cycle. It returns the block to COLLECT, clears cnt, shreg and err, drops tok_valid, and the bit offered in that cycle is not consumed.
- cnt is 4 bits, saturates logic at 10, and never wraps.
- The codeword set is a complete prefix code except the all-zero 10-bit string. Exactly one match is possible at each length, so no priority between entries is required.

## Timing
- Latency: tok_valid rises the cycle after the last codeword bit is accepted.
- In the tok_ready handshake cycle bit_ready is still 0. The first bit of the next codeword is accepted no earlier than the following cycle.
- Peak throughput is one token per (code_len + 1) cycles.
- Bubbles on bit_valid stall accumulation without loss, since cnt and shreg hold their values.
- tok_ready held low keeps HOLD indefinitely. No bits are accepted while the token waits.
- rst mid-codeword: all partial bits are discarded immediately (asynchronous) and outputs go to 0.
- err rises the cycle after the 10th bit is accepted.

## Structure
- Shared package cavlc_pkg holds:
  - constants MAX_CT_LEN = 10 and MIN_CT_LEN = 4;
  - the typedef for the token struct {t1s[1:0], tc[4:0], len[3:0]};
  - the nC-class enum (shared with the other coeff_token tables).
- Sub-module coeff_token_nc4to8_match: purely combinational. Input is (len, bits[9:0]); outputs are hit, t1s and tc. It is a case on {len, bits} holding the 62 Table 9-5 entries.
- The top level contains the FSM, shift register, counter and output registers.

## Test plan
- Bits 1,1,1,1 with tok_ready = 1 -> tok_valid in cycle 5, with t1s = 0, tc = 0, code_len = 4; bit_ready = 0 in cycle 5.
- "01101" then "0000000001" streamed back-to-back -> tokens (3, 8, 5) then (0, 16, 10). There is exactly one idle bit_ready cycle between them.
- "000000111" followed by "0000001110" -> (1, 13, 9), then (1, 13, 9) again. The 10-bit string must not match, because the 9-bit prefix fires first.
- "0000000000" -> err = 1 the cycle after bit 10, bit_ready stays 0. flush then gives err = 0, and "1110" decodes to (1, 1, 4).
- "01010" with tok_ready low for 6 cycles and bit_valid high -> token (1, 4, 5) held stable. No bits are consumed until tok_ready = 1.
- rst asserted after 3 bits of "0001111" -> all outputs 0. A fresh "1100" then decodes to (3, 3, 4).
